// File: rtl/vec_feeder.sv
// Sequential front-end for the 4-element dot-product core: packs operand pairs into A/B registers,
// captures the core result and returns it on a valid/ready port. Optional: VEC_FEEDER_LAST_EN.
module vec_feeder #(
    parameter int unsigned BITS_NUM = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BITS_NUM-1:0]   in_a,
    input  logic [BITS_NUM-1:0]   in_b,
`ifdef VEC_FEEDER_LAST_EN
    input  logic                  in_last,
`endif
    output logic [BITS_NUM-1:0]   vec_a1,
    output logic [BITS_NUM-1:0]   vec_a2,
    output logic [BITS_NUM-1:0]   vec_a3,
    output logic [BITS_NUM-1:0]   vec_a4,
    output logic [BITS_NUM-1:0]   vec_b1,
    output logic [BITS_NUM-1:0]   vec_b2,
    output logic [BITS_NUM-1:0]   vec_b3,
    output logic [BITS_NUM-1:0]   vec_b4,
    input  logic [2*BITS_NUM+1:0] dp_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*BITS_NUM+1:0] out_data
);

    typedef enum logic [1:0] {StFill, StLaunch, StHold} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              idx_q, idx_d;
    logic [BITS_NUM-1:0]     vec_a_q [4];
    logic [BITS_NUM-1:0]     vec_a_d [4];
    logic [BITS_NUM-1:0]     vec_b_q [4];
    logic [BITS_NUM-1:0]     vec_b_d [4];
    logic [2*BITS_NUM+1:0]   out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    last_pair;

`ifdef VEC_FEEDER_LAST_EN
    // A short vector launches early; untouched slots still hold their cleared zeros.
    assign last_pair = (idx_q == 2'd3) || in_last;
`else
    assign last_pair = (idx_q == 2'd3);
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        vec_a_d     = vec_a_q;
        vec_b_d     = vec_b_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;
        unique case (state_q)
            StFill: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    vec_a_d[idx_q] = in_a;
                    vec_b_d[idx_q] = in_b;
                    idx_d          = idx_q + 2'd1;
                    if (last_pair) begin
                        state_d = StLaunch;
                    end
                end
            end
            StLaunch: begin
                // Core has had a full cycle to settle on the registered operands.
                out_data_d  = dp_result;
                out_valid_d = 1'b1;
                state_d     = StHold;
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    idx_d       = 2'd0;
                    vec_a_d     = '{default: '0};
                    vec_b_d     = '{default: '0};
                    state_d     = StFill;
                end
            end
            default: begin
                state_d = StFill;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StFill;
            idx_q       <= 2'd0;
            vec_a_q     <= '{default: '0};
            vec_b_q     <= '{default: '0};
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            vec_a_q     <= vec_a_d;
            vec_b_q     <= vec_b_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign vec_a1    = vec_a_q[0];
    assign vec_a2    = vec_a_q[1];
    assign vec_a3    = vec_a_q[2];
    assign vec_a4    = vec_a_q[3];
    assign vec_b1    = vec_b_q[0];
    assign vec_b2    = vec_b_q[1];
    assign vec_b3    = vec_b_q[2];
    assign vec_b4    = vec_b_q[3];
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_vec_feeder.sv
// Scoreboard bench for vec_feeder with a combinational dot-product core model.
// Exercises the short-vector path when VEC_FEEDER_LAST_EN is defined.
module tb_vec_feeder;

    localparam int unsigned BITS_NUM = 4;
    localparam int unsigned RW       = 2 * BITS_NUM + 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [BITS_NUM-1:0] in_a = '0;
    logic [BITS_NUM-1:0] in_b = '0;
    logic                in_last = 1'b0;
    logic [BITS_NUM-1:0] vec_a1, vec_a2, vec_a3, vec_a4;
    logic [BITS_NUM-1:0] vec_b1, vec_b2, vec_b3, vec_b4;
    logic [RW-1:0]       dp_result;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [RW-1:0]       out_data;

    int n_total  = 0;
    int n_passed = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    // Core model: plain sum of element products.
    assign dp_result = RW'({6'b0, vec_a1} * {6'b0, vec_b1}) + RW'({6'b0, vec_a2} * {6'b0, vec_b2})
                     + RW'({6'b0, vec_a3} * {6'b0, vec_b3}) + RW'({6'b0, vec_a4} * {6'b0, vec_b4});

    vec_feeder #(.BITS_NUM(BITS_NUM)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef VEC_FEEDER_LAST_EN
        .in_last   (in_last),
`endif
        .vec_a1    (vec_a1),
        .vec_a2    (vec_a2),
        .vec_a3    (vec_a3),
        .vec_a4    (vec_a4),
        .vec_b1    (vec_b1),
        .vec_b2    (vec_b2),
        .vec_b3    (vec_b3),
        .vec_b4    (vec_b4),
        .dp_result (dp_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Caller is at a negedge; returns at the negedge after the handshake edge.
    task automatic send(input int a, input int b, input bit last, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        in_a     = BITS_NUM'(a);
        in_b     = BITS_NUM'(b);
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Monitor: pops one expected value per result, then checks it stays stable while held.
    initial begin
        bit      seen = 1'b0;
        int      cur  = 0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", int'(out_data), -1);
                    end else begin
                        cur = exp_q.pop_front();
                        check("out_data", int'(out_data), cur);
                    end
                    seen = 1'b1;
                end else begin
                    check("out_data_stable", int'(out_data), cur);
                end
            end else begin
                seen = 1'b0;
            end
        end
    end

    initial begin
        int n;
        // Reset values
        #12;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_vec_a1", int'(vec_a1), 0);
        check("rst_vec_b4", int'(vec_b4), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back fill, out_ready high: 5+12+21+32 = 70
        exp_q.push_back(70);
        send(1, 5, 0, 0);
        send(2, 6, 0, 0);
        send(3, 7, 0, 0);
        send(4, 8, 0, 0);
        check("launch_out_valid", int'(out_valid), 0);
        check("launch_in_ready", int'(in_ready), 0);
        check("launch_vec_a4", int'(vec_a4), 4);
        @(negedge clk);
        check("hold_out_valid", int'(out_valid), 1);
        @(negedge clk);
        check("drain_in_ready", int'(in_ready), 1);
        check("drain_out_valid", int'(out_valid), 0);
        check("drain_vec_a1", int'(vec_a1), 0);

        // Maximum operands with back-pressure: 900, extra pulses ignored
        out_ready = 1'b0;
        exp_q.push_back(900);
        for (int i = 0; i < 4; i++) send(15, 15, 0, 0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            in_valid = 1'b1;
            in_a     = 4'd9;
            in_b     = 4'd9;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_released_valid", int'(out_valid), 0);
        check("bp_cleared_a1", int'(vec_a1), 0);
        check("bp_cleared_b4", int'(vec_b4), 0);

        // Gaps between pairs: 1+0+30+49 = 80
        exp_q.push_back(80);
        send(1, 1, 0, 0);
        send(0, 9, 0, 1);
        send(15, 2, 0, 2);
        send(7, 7, 0, 3);
        repeat (3) @(negedge clk);

        // Reset mid-fill discards the partial vector
        send(5, 5, 0, 0);
        send(6, 6, 0, 0);
        rst_n = 1'b0;
        #2;
        check("midrst_vec_a1", int'(vec_a1), 0);
        check("midrst_vec_b2", int'(vec_b2), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(16);
        for (int i = 0; i < 4; i++) send(2, 2, 0, 0);
        repeat (3) @(negedge clk);

`ifdef VEC_FEEDER_LAST_EN
        // Short vector: 3*4 + 3*4 = 24, slots 3/4 stay zero
        exp_q.push_back(24);
        send(3, 4, 0, 0);
        send(3, 4, 1, 0);
        check("short_vec_a2", int'(vec_a2), 3);
        check("short_vec_a3", int'(vec_a3), 0);
        check("short_vec_a4", int'(vec_a4), 0);
        check("short_vec_b3", int'(vec_b3), 0);
        check("short_vec_b4", int'(vec_b4), 0);
        repeat (3) @(negedge clk);
        exp_q.push_back(4);
        for (int i = 0; i < 4; i++) send(1, 1, 0, 0);
        repeat (3) @(negedge clk);
`endif

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/vec_feeder.md
# vec_feeder

Sequential front-end for the combinational 4-element dot-product core. It accepts operand pairs (a_i, b_i) one per valid/ready handshake and packs them into the four A/B element registers that drive the core. It then captures the core's 10-bit result and returns it on a valid/ready output port. It is the initiator side of the dot-product interface: it drives the core's operand inputs and consumes its result.

## Interface
- `BITS_NUM`, default 4: element width in bits; the result width is `2*BITS_NUM+2`.
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: block can accept a pair; high only in FILL.
- `in_a` input BITS_NUM: element of vector A, unsigned.
- `in_b` input BITS_NUM: element of vector B, unsigned.
- `in_last` input 1: marks the final pair of a short vector. Present only with `VEC_FEEDER_LAST_EN`.
- `vec_a1..vec_a4` output BITS_NUM each: registered A elements driving the core.
- `vec_b1..vec_b4` output BITS_NUM each: registered B elements driving the core.
- `dp_result` input 2*BITS_NUM+2: combinational dot product from the core.
- `out_valid` output 1: captured result valid.
- `out_ready` input 1: downstream accepts the result.
- `out_data` output 2*BITS_NUM+2: captured result.

## Operation
- Input handshake fires when `in_valid && in_ready` at a rising edge. Output handshake fires when `out_valid && out_ready` at a rising edge.
- The state machine has three states: FILL, LAUNCH and HOLD. Reset enters FILL with `idx=0`.
- **FILL:**
  - Each input handshake writes `in_a`/`in_b` to `vec_a[idx+1]`/`vec_b[idx+1]`, then `idx` increments.
  - The handshake with `idx==3` moves the machine to LAUNCH.
  - `in_valid` low means the machine holds state and `idx`.
- **LAUNCH:**
  - Lasts exactly one cycle, giving the core a full cycle to settle.
  - At the next edge, `dp_result` is latched into `out_data`, `out_valid` goes high, and the machine moves to HOLD.
- **HOLD:**
  - `out_data` and `out_valid` stay stable until the output handshake.
  - On the output handshake: `out_valid` goes to 0, all `vec_*` registers clear to 0, `idx` goes to 0, and the machine returns to FILL.
- `in_ready` is 0 in LAUNCH and HOLD, so no pairs are accepted while a result is pending.
- **Arithmetic:** the block does no arithmetic of its own. The maximum result is 4*(2^BITS_NUM-1)^2, which is 900 for BITS_NUM=4 and fits the result width. `dp_result` is captured unmodified.
- **Reset:**
  - Reset is asynchronous, at any time, including mid-fill or in HOLD.
  - It forces FILL, `idx=0`, all `vec_*` to 0, `out_data=0` and `out_valid=0`.
  - A partially filled vector is discarded.
- **Reset values:**
  - `in_ready=1`
  - `out_valid=0`
  - `out_data=0`
  - `vec_a1..4=0`, `vec_b1..4=0`

## Timing
- The 4th input handshake occurs at edge N.
- `vec_*` are valid from edge N, and the machine is in LAUNCH during cycle N→N+1.
- `out_valid` rises at edge N+1, so latency from the last accepted pair to the result is 1 cycle.
- If `out_ready` is held high, the output handshake occurs at edge N+2 and `in_ready` is high again from N+2.
- Peak throughput is one vector per 6 cycles: 4 fill cycles, 1 launch cycle and 1 drain cycle.
- All outputs are registered except `in_ready`, which is decoded from the state register with no combinational path from any input.

## Configuration
- **`VEC_FEEDER_LAST_EN` defined:**
  - The `in_last` port exists.
  - An input handshake with `in_last=1` goes to LAUNCH immediately after writing its element.
  - Unwritten element slots keep their cleared value of 0, so the result is the dot product of the short vector.
  - `in_last` on the 4th pair is equivalent to a normal fill.
- **`VEC_FEEDER_LAST_EN` undefined:**
  - The `in_last` port is absent.
  - Every vector is exactly 4 pairs.

## Test plan
The bench models the core as `dp_result = Σ vec_ai*vec_bi`, combinationally.
- Pairs (1,5),(2,6),(3,7),(4,8) back-to-back with `out_ready=1` → `out_valid` one cycle after the 4th handshake, `out_data=70`, `in_ready` high again the following cycle.
- All elements 15, with `out_ready` held low 5 cycles → `out_data=900` held stable with `out_valid=1` throughout, `in_ready=0`, and extra `in_valid` pulses ignored.
- `in_valid` gaps of 0–3 cycles between pairs (1,1),(0,9),(15,2),(7,7) → `out_data=1+0+30+49=80`.
- `rst_n` pulsed low after 2 pairs, then (2,2)×4 → `out_data=16`, with no trace of the discarded pairs.
- With `VEC_FEEDER_LAST_EN`: pairs (3,4) then (3,4) with `in_last=1` → `vec_a3`, `vec_a4`, `vec_b3`, `vec_b4` all 0 and `out_data=24`. The next full vector (1,1)×4 gives `out_data=4`.
